// File: rtl/tdm_frame_receiver_pkg.sv
// Shared definitions for the TDM frame link: state encoding, slot index sizing
// and default geometry common to the transmit and receive blocks.
package tdm_frame_receiver_pkg;

  localparam int unsigned DefDataW    = 4;
  localparam int unsigned DefNumSlots = 4;

  typedef enum logic [0:0] {
    StIdle,
    StRecv
  } rx_state_e;

  function automatic int unsigned slot_idx_w(input int unsigned num_slots);
    return (num_slots > 2) ? $clog2(num_slots) : 1;
  endfunction

endpackage

// File: rtl/tdm_gap_timer.sv
// Saturating idle-cycle counter. It pulses timeout on the tick that brings the count
// to GapMax. A GapMax of 0 disables the timeout.
module tdm_gap_timer #(
  parameter int unsigned GapMax = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic tick_i,
  output logic timeout_o
);

  localparam int unsigned CntW = (GapMax > 0) ? $clog2(GapMax + 1) : 1;

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (tick_i && (cnt_q != CntW'(GapMax))) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign timeout_o = (GapMax != 0) && tick_i && !clear_i && (cnt_q == CntW'(GapMax - 1));

endmodule

// File: rtl/tdm_frame_receiver.sv
// Reassembles time-multiplexed slot words into a frame and commits all slots at
// once when the last slot arrives. Aborted frames never disturb out_data_o.
module tdm_frame_receiver
  import tdm_frame_receiver_pkg::*;
#(
  parameter int unsigned DataW    = DefDataW,
  parameter int unsigned NumSlots = DefNumSlots,
  parameter int unsigned GapMax   = 15
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic                      in_valid_i,
  input  logic                      in_sof_i,
  input  logic [DataW-1:0]          in_data_i,
  output logic [NumSlots*DataW-1:0] out_data_o,
  output logic                      frame_done_o,
  output logic                      frame_err_o,
  output logic                      busy_o
);

  localparam int unsigned SlotW = slot_idx_w(NumSlots);
  localparam logic [SlotW-1:0] LastSlot = SlotW'(NumSlots - 1);

  rx_state_e                  state_q;
  logic [SlotW-1:0]           cnt_q;
  logic [DataW-1:0]           shadow_q [NumSlots-1];
  logic [(NumSlots-1)*DataW-1:0] shadow_flat;
  logic                       gap_clear, gap_tick, gap_timeout;

  always_comb begin
    shadow_flat = '0;
    for (int k = 0; k < NumSlots - 1; k++) begin
      shadow_flat[k*DataW +: DataW] = shadow_q[k];
    end
  end

  // Idle cycles count only while a frame is open and enabled; any beat restarts the count.
  assign gap_clear = (state_q != StRecv) || in_valid_i || !en_i;
  assign gap_tick  = (state_q == StRecv) && en_i && !in_valid_i;

  tdm_gap_timer #(
    .GapMax (GapMax)
  ) u_gap_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (gap_clear),
    .tick_i    (gap_tick),
    .timeout_o (gap_timeout)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      out_data_o   <= '0;
      frame_done_o <= 1'b0;
      frame_err_o  <= 1'b0;
      for (int k = 0; k < NumSlots - 1; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      frame_done_o <= 1'b0;
      frame_err_o  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (en_i && in_valid_i && in_sof_i) begin
            shadow_q[0] <= in_data_i;
            cnt_q       <= SlotW'(1);
            state_q     <= StRecv;
          end
        end
        StRecv: begin
          if (!en_i) begin
            frame_err_o <= 1'b1;
            cnt_q       <= '0;
            state_q     <= StIdle;
          end else if (in_valid_i && in_sof_i) begin
            // Early SOF restarts the frame in place with this word as slot 0.
            frame_err_o <= 1'b1;
            shadow_q[0] <= in_data_i;
            cnt_q       <= SlotW'(1);
          end else if (in_valid_i) begin
            if (cnt_q == LastSlot) begin
              out_data_o   <= {in_data_i, shadow_flat};
              frame_done_o <= 1'b1;
              cnt_q        <= '0;
              state_q      <= StIdle;
            end else begin
              shadow_q[cnt_q] <= in_data_i;
              cnt_q           <= cnt_q + SlotW'(1);
            end
          end else if (gap_timeout) begin
            frame_err_o <= 1'b1;
            cnt_q       <= '0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o = (state_q == StRecv);

endmodule

// File: tb/tb_tdm_frame_receiver.sv
// Directed bench for tdm_frame_receiver: nominal, gap, timeout, early SOF,
// enable/stray handling and asynchronous reset mid-frame.
module tb_tdm_frame_receiver;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic        in_sof;
  logic [3:0]  in_data;
  logic [15:0] out_data;
  logic        frame_done;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  tdm_frame_receiver #(
    .DataW    (4),
    .NumSlots (4),
    .GapMax   (15)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .in_valid_i   (in_valid),
    .in_sof_i     (in_sof),
    .in_data_i    (in_data),
    .out_data_o   (out_data),
    .frame_done_o (frame_done),
    .frame_err_o  (frame_err),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then settle just after the rising edge.
  task automatic step(input logic e, input logic v, input logic s, input logic [3:0] d);
    @(negedge clk);
    en       = e;
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic [15:0] d, input logic dn, input logic er,
                      input logic b);
    check({tag, ".data"}, 32'(out_data), 32'(d));
    check({tag, ".done"}, 32'(frame_done), 32'(dn));
    check({tag, ".err"}, 32'(frame_err), 32'(er));
    check({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 4'h0;
    #12;
    outs("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal frame
    step(1, 1, 1, 4'h3); outs("nom.s0", 16'h0000, 0, 0, 1);
    step(1, 1, 0, 4'h7); outs("nom.s1", 16'h0000, 0, 0, 1);
    step(1, 1, 0, 4'hB); outs("nom.s2", 16'h0000, 0, 0, 1);
    step(1, 1, 0, 4'hF); outs("nom.s3", 16'hFB73, 1, 0, 0);
    step(1, 0, 0, 4'h0); outs("nom.after", 16'hFB73, 0, 0, 0);

    // Gaps inside a frame below the timeout
    step(1, 1, 1, 4'h3);
    step(1, 1, 0, 4'h7);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 4'h0); outs("gap.idle", 16'hFB73, 0, 0, 1);
    end
    step(1, 1, 0, 4'hB);
    step(1, 1, 0, 4'hF); outs("gap.commit", 16'hFB73, 1, 0, 0);

    // Timeout after 15 idle cycles
    step(1, 1, 1, 4'h1);
    step(1, 1, 0, 4'h2);
    for (int i = 0; i < 14; i++) begin
      step(1, 0, 0, 4'h0); outs("to.idle", 16'hFB73, 0, 0, 1);
    end
    step(1, 0, 0, 4'h0); outs("to.fire", 16'hFB73, 0, 1, 0);
    step(1, 0, 0, 4'h0); outs("to.after", 16'hFB73, 0, 0, 0);

    // Early SOF
    step(1, 1, 1, 4'h1);
    step(1, 1, 0, 4'h2);
    step(1, 1, 1, 4'h9); outs("esof.err", 16'hFB73, 0, 1, 1);
    step(1, 1, 0, 4'hA); outs("esof.s1", 16'hFB73, 0, 0, 1);
    step(1, 1, 0, 4'hB);
    step(1, 1, 0, 4'hC); outs("esof.commit", 16'hCBA9, 1, 0, 0);

    // Stray word in IDLE
    step(1, 1, 0, 4'h5); outs("stray", 16'hCBA9, 0, 0, 0);

    // Enable dropped mid-frame
    step(1, 1, 1, 4'h6);
    step(1, 1, 0, 4'h7); outs("en.s1", 16'hCBA9, 0, 0, 1);
    step(0, 0, 0, 4'h0); outs("en.drop", 16'hCBA9, 0, 1, 0);
    step(0, 0, 0, 4'h0); outs("en.once", 16'hCBA9, 0, 0, 0);

    // Full frame with enable low is ignored
    step(0, 1, 1, 4'h1); outs("enlo.s0", 16'hCBA9, 0, 0, 0);
    step(0, 1, 0, 4'h2);
    step(0, 1, 0, 4'h3);
    step(0, 1, 0, 4'h4); outs("enlo.s3", 16'hCBA9, 0, 0, 0);

    // Asynchronous reset between edges mid-frame
    step(1, 1, 1, 4'h8);
    step(1, 1, 0, 4'h9);
    #2;
    rst_n = 1'b0;
    #1;
    outs("arst", 16'h0000, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 1, 4'h4);
    step(1, 1, 0, 4'h3);
    step(1, 1, 0, 4'h2);
    step(1, 1, 0, 4'h1); outs("post.commit", 16'h1234, 1, 0, 0);
    step(1, 0, 0, 4'h0); outs("post.after", 16'h1234, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_frame_receiver.md
Name: tdm_frame_receiver

Overview:
Receive end of the shared-bus routing path. A sender time-multiplexes NUM_SLOTS source words onto one DATA_W-bit link, one slot per valid beat, starting with a start-of-frame marker. This block reassembles each frame into per-destination registers and commits all slots together when the frame completes. It drives the destination LED groups, or any downstream consumer, from a single serial stream.

Parameters:
DATA_W, 4, width of one slot word
NUM_SLOTS, 4, slots per frame (2..16)
GAP_MAX, 15, max consecutive idle cycles inside a frame before abort; 0 disables timeout

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  receive enable; low aborts any frame in progress
in_valid  input  1  in_data holds a slot word this cycle
in_sof  input  1  qualifies in_valid; marks slot 0 of a new frame
in_data  input  DATA_W  slot word
out_data  output  NUM_SLOTS*DATA_W  committed frame; slot k at [k*DATA_W +: DATA_W]
frame_done  output  1  one-cycle pulse, out_data just updated
frame_err  output  1  one-cycle pulse, frame aborted (no commit)
busy  output  1  high while a frame is partially received

Behaviour:
- Reset, async on rst_n low: out_data=0, frame_done=0, frame_err=0, busy=0, state IDLE, slot counter 0, gap counter 0, shadow registers 0.
- States: IDLE, RECV. busy = (state==RECV), registered.
- IDLE:
  - en & in_valid & in_sof: shadow[0]<=in_data, cnt<=1, gap<=0, go to RECV.
  - in_valid without in_sof: word dropped silently, no error.
- RECV, en high:
  - in_valid & !in_sof: shadow[cnt]<=in_data, cnt++, gap<=0.
  - If cnt==NUM_SLOTS-1 on that beat: same edge loads out_data with the shadow slots plus the incoming word, pulses frame_done, returns to IDLE. Latency is 1 clock from sampling the last word to out_data/frame_done visible.
  - in_valid & in_sof (early SOF): frame_err pulses; partial frame discarded; in_data becomes new slot 0; cnt<=1; stays in RECV.
  - !in_valid: gap++. If GAP_MAX!=0 and gap reaches GAP_MAX, frame_err pulses and state goes to IDLE, no commit.
- en low in RECV: frame_err pulses once, IDLE, no commit. en low in IDLE: all inputs ignored, no pulses.
- out_data changes only on frame_done; it holds the last good frame indefinitely, including across errors.
- frame_done and frame_err are never high in the same cycle. Early SOF yields frame_err only.
- Reset mid-frame: immediate return to reset values, partial frame lost, no pulses.
- Slot counter width is clog2(NUM_SLOTS). The counter never wraps; the final slot always commits.
- Gap counter saturates at GAP_MAX.

Decomposition:
- Shared package: state enum (IDLE, RECV), slot-index width function, default DATA_W and NUM_SLOTS constants shared with the matching transmit-side block.
- One natural sub-module: tdm_gap_timer, a saturating idle counter with clear and timeout pulse. Shadow and commit logic stay in the top.

Test Plan:
- Nominal: SOF+0x3, then 0x7, 0xB, 0xF on consecutive cycles -> frame_done 1 cycle after 0xF; out_data=0xFB73; busy high 3 cycles.
- Gaps: same frame with 5 idle cycles between slots 1 and 2, GAP_MAX=15 -> commits 0xFB73, no frame_err.
- Timeout: SOF+0x1, 0x2, then 15 idle cycles -> frame_err pulse, busy low, out_data keeps prior 0xFB73.
- Early SOF: SOF+0x1, 0x2, SOF+0x9, 0xA, 0xB, 0xC -> frame_err at the second SOF; then frame_done with out_data=0xCBA9.
- Enable/stray: in_valid 0x5 without SOF in IDLE -> no pulses. en dropped after slot 1 -> single frame_err, no commit. en low with a full frame -> nothing.
- Async reset asserted mid-frame between edges -> outputs 0 immediately; next full frame 0x4,0x3,0x2,0x1 -> out_data=0x1234.
